// File: rtl/icap_write_feeder.sv
// icap_write_feeder: buffers a last-tagged bitstream word stream and drives the
// write side of an ICAP port (cclk, ccs_n, cwe_n, cdata), honouring cbusy.
//
// Handshakes:
//   upstream : a word transfers on a rising clk edge where s_valid & s_ready.
//              s_ready never depends on s_valid.
//   ICAP     : a word is consumed on a rising clk edge where ccs_n=0, cwe_n=0 and
//              cbusy=0. Until then cdata and ccs_n are held.
// The write sequence is IDLE -> WSETUP (WE before CS) -> WRITE <-> PAUSE -> WEND -> IDLE.
// The current state is visible on state_dbg.
module icap_write_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter bit BITSWAP    = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        abort,
  output logic        icap_cclk,
  output logic        icap_ccs_n,
  output logic        icap_cwe_n,
  output logic [31:0] icap_cdata,
  input  logic        icap_cbusy,
  output logic        done,
  output logic [31:0] words_written,
  output logic [2:0]  state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WSETUP = 3'd1,
    S_WRITE  = 3'd2,
    S_PAUSE  = 3'd3,
    S_WEND   = 3'd4
  } state_t;

  state_t state, state_d;

  // FIFO storage: bit 32 carries the last tag alongside the data word.
  logic [32:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        push, pop, consume;
  logic [32:0] head;
  logic [31:0] head_mapped;

  // Output register: icap_cdata holds the word, out_valid/out_last qualify it.
  logic        out_valid, out_valid_d, out_last;
  logic        last_seen, rdy_en;
  logic        ccs_n_d, cwe_n_d, done_d;

  assign icap_cclk  = clk;
  assign state_dbg  = state;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];

  // rdy_en keeps s_ready low while in reset and for the first edge after it.
  assign s_ready = rdy_en & ~fifo_full & ~abort & ~last_seen;
  assign push    = s_valid & s_ready;
  assign consume = ~icap_ccs_n & ~icap_cwe_n & ~icap_cbusy;
  // Refill the output register when it is empty or its word leaves this cycle.
  assign pop     = ~abort & ~fifo_empty & (~out_valid | consume);

  // Byte-wise bit reversal of the FIFO head (ICAP byte convention), or pass-through.
  for (genvar i = 0; i < 32; i++) begin : g_map
    if (BITSWAP) begin : g_swap
      assign head_mapped[i] = head[(i / 8) * 8 + 7 - (i % 8)];
    end else begin : g_raw
      assign head_mapped[i] = head[i];
    end
  end

  // Occupancy of the output register after this edge.
  always_comb begin
    out_valid_d = out_valid;
    if (abort)        out_valid_d = 1'b0;
    else if (pop)     out_valid_d = 1'b1;
    else if (consume) out_valid_d = 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_d;
  end

  // FSM next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (push) state_d = S_WSETUP;
      S_WSETUP: state_d = S_WRITE;
      S_WRITE: begin
        if (consume && out_last) state_d = S_WEND;
        else if (!out_valid_d)   state_d = S_PAUSE;
      end
      S_PAUSE:  if (out_valid) state_d = S_WRITE;
      S_WEND:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // FSM outputs, computed for the next state so the pins are registered.
  always_comb begin
    ccs_n_d = ~((state_d == S_WRITE) && out_valid_d);
    cwe_n_d = (state_d == S_IDLE);
    done_d  = (state == S_WEND) && !abort;
  end

  // Registered ICAP control pins and completion pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      icap_ccs_n <= 1'b1;
      icap_cwe_n <= 1'b1;
      done       <= 1'b0;
    end else begin
      icap_ccs_n <= ccs_n_d;
      icap_cwe_n <= cwe_n_d;
      done       <= done_d;
    end
  end

  // FIFO storage write (no reset needed: pointers qualify the contents).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
  end

  // FIFO pointers, output register, last tracking and the word counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      icap_cdata    <= '0;
      last_seen     <= 1'b0;
      rdy_en        <= 1'b0;
      words_written <= '0;
    end else begin
      rdy_en    <= 1'b1;
      out_valid <= out_valid_d;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) begin
        icap_cdata <= head_mapped;
        out_last   <= head[32];
      end
      if (abort || state == S_WEND) last_seen <= 1'b0;
      else if (push && s_last)      last_seen <= 1'b1;
      // A consume can never coincide with the first accept in IDLE.
      if (state == S_IDLE && push) words_written <= '0;
      else if (consume)            words_written <= words_written + 32'd1;
    end
  end

endmodule
